// File: rtl/count_run_controller.sv
// count_run_controller
// Runs a counter from 0 up to a latched terminal count, advancing once per
// selectable period. A run can be paused (the period timer freezes and
// resumes where it left off) or aborted (back to IDLE with the count cleared).
// Completion is signalled by a one-cycle DONE state with a registered pulse.
module count_run_controller #(
    parameter int CNT_W       = 5,
    parameter int DIV_W       = 28,
    parameter int BASE_PERIOD = 50000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [1:0]       speed,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Cycles per tick at speed 01, carried in the divider's own width.
    localparam logic [DIV_W-1:0] BASE = DIV_W'(BASE_PERIOD);

    logic [DIV_W-1:0] divider;   // cycles remaining until the next tick
    logic [1:0]       speed_q;   // rate select captured at start
    logic [CNT_W-1:0] limit_q;   // terminal count captured at start
    logic [CNT_W-1:0] count_inc;

    // Reload value for the divider: tick period minus one for a rate select.
    function automatic logic [DIV_W-1:0] period_m1(input logic [1:0] sel);
        logic [DIV_W-1:0] period;
        case (sel)
            2'd0:    period = DIV_W'(1);
            2'd1:    period = BASE;
            2'd2:    period = BASE << 1;
            default: period = BASE << 2;
        endcase
        return period - DIV_W'(1);
    endfunction

    assign count_inc = count + CNT_W'(1);

    // A tick is an advance that actually happens this cycle, so pause and
    // abort suppress it even when the divider has expired.
    assign tick = (state == ST_RUN) && (divider == '0) && !pause && !abort;
    assign busy = (state == ST_RUN) || (state == ST_PAUSE);

    // Run sequencing: state, count, period divider, latched run settings and
    // the registered completion pulse.
    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values; blocking = would leak new values into
    // later statements of this block.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            divider <= '0;
            done    <= 1'b0;
            speed_q <= 2'd0;
            limit_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        speed_q <= speed;
                        limit_q <= limit;
                        count   <= '0;
                        if (limit == '0) begin
                            // Nothing to count: complete immediately.
                            divider <= '0;
                            state   <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            divider <= period_m1(speed);
                            state   <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        count   <= '0;
                        divider <= '0;
                        state   <= ST_IDLE;
                    end else if (pause) begin
                        // Divider and count hold through the pause.
                        state <= ST_PAUSE;
                    end else if (divider == '0) begin
                        count   <= count_inc;
                        divider <= period_m1(speed_q);
                        if (count_inc == limit_q) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        divider <= divider - DIV_W'(1);
                    end
                end

                ST_PAUSE: begin
                    if (abort) begin
                        count   <= '0;
                        divider <= '0;
                        state   <= ST_IDLE;
                    end else if (!pause) begin
                        // Resume from the held divider value.
                        state <= ST_RUN;
                    end
                end

                default: begin
                    // DONE lasts one cycle; abort and start are ignored here.
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_run_controller.sv
// Testbench for count_run_controller (BASE_PERIOD = 4).
// Stimulus computes, for each run, the expected tick/done events from the
// behavioural rules (a run cycle advances the period timer only when pause is
// low in that cycle and was low in the previous run cycle; every period-th
// advance is a tick) and queues them. An independent monitor pops one
// expected event whenever the DUT shows tick or done and compares it.
module tb_count_run_controller;

    localparam int CNT_W = 5;
    localparam int DIV_W = 28;
    localparam int BP    = 4;
    localparam int MAXR  = 600;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       speed = 2'd0;
    logic [CNT_W-1:0] limit = '0;
    logic [CNT_W-1:0] count;
    logic             tick;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        bit is_done;
        int cyc;
        int cnt;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    int p_start = -1;
    int p_len   = 0;

    count_run_controller #(
        .CNT_W      (CNT_W),
        .DIV_W      (DIV_W),
        .BASE_PERIOD(BP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .pause(pause),
        .abort(abort),
        .speed(speed),
        .limit(limit),
        .count(count),
        .tick (tick),
        .busy (busy),
        .done (done),
        .state(state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Pause level requested in run cycle r of the current run.
    function automatic bit pv(input int r);
        return (r >= p_start) && (r < p_start + p_len);
    endfunction

    // Monitor: every observed tick or done must match the next queued event.
    always @(negedge clock) begin
        if (!reset && (tick === 1'b1 || done === 1'b1)) begin
            if (exp_q.size() == 0) begin
                check("event_expected", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check(mon_e.is_done ? "done_cycle" : "tick_cycle", cyc, mon_e.cyc);
                check("event_is_done", int'(done), int'(mon_e.is_done));
                check("event_is_tick", int'(tick), int'(!mon_e.is_done));
                check("event_count", int'(count), mon_e.cnt);
                check("event_busy", int'(busy), int'(!mon_e.is_done));
            end
        end
    end

    // One run: spd/lim at start, pause high for run cycles [ps, ps+pl),
    // abort in run cycle ab (-1 for none), start held high through the run
    // when hold_start is set. Speed/limit are scrambled after the start edge.
    task automatic run_case(input int spd, input int lim, input int ps, input int pl,
                            input int ab, input bit hold_start);
        int per;
        int s;
        int active;
        int cnt;
        int last;
        bit aborted;
        per = (spd == 0) ? 1 : (spd == 1) ? BP : (spd == 2) ? 2 * BP : 4 * BP;
        p_start = ps;
        p_len   = pl;
        @(posedge clock); #1;
        start = 1'b1;
        speed = 2'(spd);
        limit = CNT_W'(lim);
        pause = 1'b0;
        abort = 1'b0;
        s       = cyc + 1;
        active  = 0;
        cnt     = 0;
        last    = -1;
        aborted = 1'b0;
        if (lim == 0) begin
            exp_q.push_back('{1'b1, s, 0});
            last = 0;
        end else begin
            for (int r = 0; r < MAXR && last < 0; r++) begin
                if (r == ab) begin
                    aborted = 1'b1;
                    last    = r;
                end else if (!pv(r) && !(r > 0 && pv(r - 1))) begin
                    active++;
                    if (active % per == 0) begin
                        exp_q.push_back('{1'b0, s + r, cnt});
                        cnt++;
                        if (cnt == lim) begin
                            exp_q.push_back('{1'b1, s + r + 1, lim});
                            last = r + 1;
                        end
                    end
                end
            end
        end
        for (int r = 0; r <= last; r++) begin
            @(posedge clock); #1;
            start = hold_start;
            speed = 2'($urandom);
            limit = CNT_W'($urandom);
            pause = pv(r);
            abort = (r == ab);
        end
        @(posedge clock); #1;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        check("end_state", int'(state), 0);
        check("end_busy", int'(busy), 0);
        check("end_done", int'(done), 0);
        check("end_tick", int'(tick), 0);
        check("end_count", int'(count), aborted ? 0 : lim);
        check("events_outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic reset_mid_run();
        int s;
        @(posedge clock); #1;
        start = 1'b1;
        speed = 2'd0;
        limit = CNT_W'(10);
        pause = 1'b0;
        abort = 1'b0;
        s = cyc + 1;
        for (int k = 0; k < 5; k++) exp_q.push_back('{1'b0, s + k, k});
        for (int r = 0; r < 5; r++) begin
            @(posedge clock); #1;
            start = 1'b0;
        end
        @(posedge clock); #1;
        check("pre_reset_count", int'(count), 5);
        check("pre_reset_state", int'(state), 1);
        reset = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        pause = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            check("reset_count", int'(count), 0);
            check("reset_state", int'(state), 0);
            check("reset_busy", int'(busy), 0);
            check("reset_done", int'(done), 0);
            check("reset_tick", int'(tick), 0);
        end
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        check("reset_events_outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("init_state", int'(state), 0);
        check("init_count", int'(count), 0);
        check("init_busy", int'(busy), 0);
        check("init_done", int'(done), 0);
        check("init_tick", int'(tick), 0);
        reset = 1'b0;

        // Directed runs.
        run_case(0, 3, -1, 0, -1, 1'b0);   // three back-to-back ticks
        run_case(1, 2, -1, 0, -1, 1'b0);   // ticks every BASE_PERIOD cycles
        run_case(3, 1, 5, 10, -1, 1'b0);   // long period with a pause window
        run_case(0, 16, 7, 1, 7, 1'b0);    // abort together with pause at count 7
        run_case(0, 0, -1, 0, 0, 1'b1);    // zero limit; start/abort held in DONE
        run_case(2, 3, 2, 3, -1, 1'b1);    // start held high through the run
        run_case(0, 31, -1, 0, -1, 1'b0);  // full-range limit, no wrap
        reset_mid_run();

        // Randomised runs.
        for (int i = 0; i < 30; i++) begin
            int spd;
            int lim;
            spd = $urandom_range(0, 3);
            lim = (spd == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
            run_case(spd, lim, $urandom_range(0, 20), $urandom_range(0, 12),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1,
                     1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
